// File: rtl/shareio_pkg.sv
// Shared constants and helpers for the shared-bus CPU time-slot multiplexer.
// Optional build macro used by the mux: SHAREIO_WRSTB_EN (single-cycle write strobe).
package shareio_pkg;

    // Peripheral classes that hang off the shared bus.
    typedef enum logic [1:0] {
        HW_VRAM    = 2'd0,
        HW_PALETTE = 2'd1,
        HW_PSG     = 2'd2,
        HW_SCROLL  = 2'd3
    } hw_type_e;

    // Legal configuration ranges.
    localparam int SHR_NCPU_MIN = 1;
    localparam int SHR_NCPU_MAX = 8;
    localparam int SHR_SLOT_MIN = 2;
    localparam int SHR_SLOT_MAX = 16;

    // Value the per-CPU read-hold registers take after reset (truncated to DW).
    localparam logic [63:0] HOLD_RST = '1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Width of an index into n items, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/shareio_cpumux_n_if.sv
// CPU-side and bus-side signal bundle of the shared-bus multiplexer.
// master = the multiplexer, slave = the CPUs plus the peripheral decoder.
interface shareio_cpumux_n_if #(
    parameter int NCPU = 2,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    import shareio_pkg::*;

    localparam int SELW = sel_w(NCPU);

    logic [NCPU-1:0]    CPACT;
    logic [NCPU*AW-1:0] CPAD;
    logic [NCPU*DW-1:0] CPOD;
    logic [NCPU-1:0]    CPRD;
    logic [NCPU-1:0]    CPWR;
    logic [NCPU*DW-1:0] CPID;
    logic [NCPU-1:0]    CPCE;
    logic [AW-1:0]      BUSADR;
    logic [DW-1:0]      BUSODT;
    logic [DW-1:0]      BUSIDT;
    logic               BUSRD;
    logic               BUSWR;
    logic [SELW-1:0]    BUSSEL;
    logic               BUSACT;

    modport master (
        input  CPACT, CPAD, CPOD, CPRD, CPWR, BUSIDT,
        output CPID, CPCE, BUSADR, BUSODT, BUSRD, BUSWR, BUSSEL, BUSACT
    );

    modport slave (
        output CPACT, CPAD, CPOD, CPRD, CPWR, BUSIDT,
        input  CPID, CPCE, BUSADR, BUSODT, BUSRD, BUSWR, BUSSEL, BUSACT
    );

endinterface

// File: rtl/shareio_rr_next.sv
// Cyclic next-active-CPU search: first index after i_cur with its active bit
// set, visiting i_cur itself last. o_any is low when no CPU is active.
module shareio_rr_next #(
    parameter int NCPU = 2,
    parameter int SELW = 1
) (
    input  logic [NCPU-1:0] i_act,
    input  logic [SELW-1:0] i_cur,
    output logic [SELW-1:0] o_idx,
    output logic            o_any
);

    logic [SELW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest active CPU wins.
    always_comb begin
        w_idx = i_cur;
        for (int off = NCPU; off >= 1; off--) begin
            for (int j = 0; j < NCPU; j++) begin
                if ((((int'(i_cur) + off) % NCPU) == j) && i_act[j]) begin
                    w_idx = SELW'(j);
                end
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = |i_act;

endmodule

// File: rtl/shareio_cpumux_n.sv
// Round-robin time-slot multiplexer giving NCPU CPUs turns on one shared
// peripheral bus. Each slot lasts SLOT_CYC cycles; the owner gets a one-cycle
// clock enable in the last cycle of its slot and its read data is frozen in a
// hold register when the slot ends.
// Build macro SHAREIO_WRSTB_EN: when defined, BUSWR pulses only in the
// mid-slot cycle instead of being held for the whole slot.
module shareio_cpumux_n
    import shareio_pkg::*;
#(
    parameter int NCPU      = 2,
    parameter int SLOT_CYC  = 4,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int SKIP_IDLE = 0
) (
    input  logic               SHCLK,
    input  logic               RESET,
    shareio_cpumux_n_if.master bus
);

    localparam int SELW = sel_w(NCPU);
    localparam int PHW  = sel_w(SLOT_CYC);

    localparam logic [PHW-1:0]  PH_LAST  = PHW'(SLOT_CYC - 1);
    localparam logic [PHW-1:0]  PH_PRE   = PHW'(SLOT_CYC - 2);
    localparam logic [SELW-1:0] OWN_LAST = SELW'(NCPU - 1);
`ifdef SHAREIO_WRSTB_EN
    localparam logic [PHW-1:0]  PH_WR    = PHW'(SLOT_CYC / 2);
`endif

    // Reject configurations outside the supported range at elaboration.
    if (NCPU < SHR_NCPU_MIN || NCPU > SHR_NCPU_MAX) begin : g_bad_ncpu
        $error("shareio_cpumux_n: NCPU out of range");
    end
    if (SLOT_CYC < SHR_SLOT_MIN || SLOT_CYC > SHR_SLOT_MAX) begin : g_bad_slot
        $error("shareio_cpumux_n: SLOT_CYC out of range");
    end

    logic [PHW-1:0]  r_ph;
    logic [SELW-1:0] r_own;
    logic            r_busact;
    logic [NCPU-1:0] r_cpce;
    logic [DW-1:0]   r_hold [NCPU];

    logic            w_slot_end;
    logic            w_pre_end;
    logic [SELW-1:0] w_rr_idx;
    logic            w_rr_any;
    logic [SELW-1:0] w_own_nxt;
    logic            w_busact_nxt;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_odt;
    logic            w_rd_req;
    logic            w_wr_req;
    logic            w_wr_win;

    assign w_slot_end = (r_ph == PH_LAST);
    assign w_pre_end  = (r_ph == PH_PRE);

    shareio_rr_next #(
        .NCPU (NCPU),
        .SELW (SELW)
    ) u_rr_next (
        .i_act (bus.CPACT),
        .i_cur (r_own),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // Owner and bus-active value to take at the next slot end.
    always_comb begin
        w_own_nxt    = r_own;
        w_busact_nxt = r_busact;
        if (SKIP_IDLE != 0) begin
            if (w_rr_any) begin
                w_own_nxt    = w_rr_idx;
                w_busact_nxt = 1'b1;
            end else begin
                w_busact_nxt = 1'b0;
            end
        end else begin
            w_own_nxt    = (r_own == OWN_LAST) ? '0 : r_own + SELW'(1);
            w_busact_nxt = 1'b1;
        end
    end

    // Slot phase counter and slot ownership; CPACT only matters at slot end.
    always_ff @(posedge SHCLK) begin
        if (RESET) begin
            r_ph     <= '0;
            r_own    <= '0;
            r_busact <= (SKIP_IDLE != 0) ? bus.CPACT[0] : 1'b1;
        end else if (w_slot_end) begin
            r_ph     <= '0;
            r_own    <= w_own_nxt;
            r_busact <= w_busact_nxt;
        end else begin
            r_ph     <= r_ph + PHW'(1);
        end
    end

    // Clock enable lands in the owner's last slot cycle; it is set one cycle
    // early because owner and bus-active cannot change inside a slot.
    always_ff @(posedge SHCLK) begin
        if (RESET) begin
            r_cpce <= '0;
        end else begin
            for (int k = 0; k < NCPU; k++) begin
                r_cpce[k] <= w_pre_end && r_busact && (r_own == SELW'(k));
            end
        end
    end

    // Freeze the owner's read data when its slot ends.
    always_ff @(posedge SHCLK) begin
        if (RESET) begin
            for (int k = 0; k < NCPU; k++) begin
                r_hold[k] <= HOLD_RST[DW-1:0];
            end
        end else if (w_slot_end && r_busact) begin
            for (int k = 0; k < NCPU; k++) begin
                if (r_own == SELW'(k)) begin
                    r_hold[k] <= bus.BUSIDT;
                end
            end
        end
    end

    // Route the owning CPU's address, write data and strobes onto the bus.
    always_comb begin
        w_adr    = '0;
        w_odt    = '0;
        w_rd_req = 1'b0;
        w_wr_req = 1'b0;
        for (int k = 0; k < NCPU; k++) begin
            if (r_own == SELW'(k)) begin
                w_adr    = bus.CPAD[k*AW +: AW];
                w_odt    = bus.CPOD[k*DW +: DW];
                w_rd_req = bus.CPRD[k];
                w_wr_req = bus.CPWR[k];
            end
        end
    end

`ifdef SHAREIO_WRSTB_EN
    assign w_wr_win = (r_ph == PH_WR);
`else
    assign w_wr_win = 1'b1;
`endif

    assign bus.BUSADR = w_adr;
    assign bus.BUSODT = w_odt;
    assign bus.BUSRD  = w_rd_req & r_busact;
    assign bus.BUSWR  = w_wr_req & r_busact & w_wr_win;
    assign bus.BUSSEL = r_own;
    assign bus.BUSACT = r_busact;
    assign bus.CPCE   = r_cpce;

    // The owner sees live bus data so it samples correctly at its enable edge.
    for (genvar k = 0; k < NCPU; k++) begin : g_cpid
        assign bus.CPID[k*DW +: DW] = (r_busact && (r_own == SELW'(k))) ? bus.BUSIDT : r_hold[k];
    end

endmodule

// File: tb/tb_shareio_cpumux_n.sv
// Directed bench for shareio_cpumux_n: four instances cover NCPU=2/3/4/1,
// round-robin and skip-idle ownership, read hold, write strobe and reset.
module tb_shareio_cpumux_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef SHAREIO_WRSTB_EN
    localparam bit WRSTB = 1'b1;
`else
    localparam bit WRSTB = 1'b0;
`endif

    shareio_cpumux_n_if #(.NCPU(2), .AW(16), .DW(8)) if_a ();
    shareio_cpumux_n_if #(.NCPU(3), .AW(16), .DW(8)) if_b ();
    shareio_cpumux_n_if #(.NCPU(4), .AW(16), .DW(8)) if_c ();
    shareio_cpumux_n_if #(.NCPU(1), .AW(16), .DW(8)) if_d ();

    shareio_cpumux_n #(.NCPU(2), .SLOT_CYC(4), .AW(16), .DW(8), .SKIP_IDLE(0))
        u_a (.SHCLK(clk), .RESET(rst), .bus(if_a));
    shareio_cpumux_n #(.NCPU(3), .SLOT_CYC(4), .AW(16), .DW(8), .SKIP_IDLE(0))
        u_b (.SHCLK(clk), .RESET(rst), .bus(if_b));
    shareio_cpumux_n #(.NCPU(4), .SLOT_CYC(4), .AW(16), .DW(8), .SKIP_IDLE(1))
        u_c (.SHCLK(clk), .RESET(rst), .bus(if_c));
    shareio_cpumux_n #(.NCPU(1), .SLOT_CYC(3), .AW(16), .DW(8), .SKIP_IDLE(0))
        u_d (.SHCLK(clk), .RESET(rst), .bus(if_d));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_ce_a;
        logic       exp_wr_a;
        logic [3:0] exp_ce_c;

        if_a.CPACT  = 2'b11;
        if_a.CPAD   = {16'hB111, 16'hA000};
        if_a.CPOD   = {8'h22, 8'h11};
        if_a.CPRD   = 2'b00;
        if_a.CPWR   = 2'b01;
        if_a.BUSIDT = 8'h3C;

        if_b.CPACT  = 3'b111;
        if_b.CPAD   = '0;
        if_b.CPOD   = '0;
        if_b.CPRD   = '0;
        if_b.CPWR   = '0;
        if_b.BUSIDT = 8'h5A;

        if_c.CPACT  = 4'b1010;
        if_c.CPAD   = '0;
        if_c.CPOD   = '0;
        if_c.CPRD   = 4'b1111;
        if_c.CPWR   = 4'b1111;
        if_c.BUSIDT = 8'h99;

        if_d.CPACT  = 1'b1;
        if_d.CPAD   = '0;
        if_d.CPOD   = '0;
        if_d.CPRD   = 1'b0;
        if_d.CPWR   = 1'b0;
        if_d.BUSIDT = 8'h00;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cycle c is the c-th cycle after reset release; checks run mid-cycle.
        for (int c = 0; c < 28; c++) begin
            if_b.BUSIDT = (c < 4) ? 8'h5A : (c < 8) ? 8'hC3 : 8'h11;
            if (c == 17) if_c.CPACT = 4'b0000;

            exp_ce_a = (c % 4 == 3) ? ((c % 8 == 3) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("A_cpce@%0d", c), if_a.CPCE, exp_ce_a);
            chk($sformatf("A_sel@%0d", c), if_a.BUSSEL, (c / 4) % 2);
            if (c < 8) begin
                exp_wr_a = (c < 4) && (WRSTB ? (c == 2) : 1'b1);
                chk($sformatf("A_buswr@%0d", c), if_a.BUSWR, exp_wr_a);
            end
            if (c == 0) begin
                chk("A_rst_busact", if_a.BUSACT, 1);
                chk("A_rst_cpid1", if_a.CPID[15:8], 8'hFF);
                chk("A_rst_cpid0", if_a.CPID[7:0], 8'h3C);
                chk("A_adr0", if_a.BUSADR, 16'hA000);
                chk("A_odt0", if_a.BUSODT, 8'h11);
            end
            if (c == 4) begin
                chk("A_adr1", if_a.BUSADR, 16'hB111);
                chk("A_odt1", if_a.BUSODT, 8'h22);
            end

            if (c == 9) begin
                chk("B_cpid0", if_b.CPID[7:0], 8'h5A);
                chk("B_cpid1", if_b.CPID[15:8], 8'hC3);
                chk("B_cpid2", if_b.CPID[23:16], 8'h11);
                chk("B_sel", if_b.BUSSEL, 2);
            end

            if (c < 4) begin
                chk($sformatf("C_rst_busact@%0d", c), if_c.BUSACT, 0);
                chk($sformatf("C_rst_cpce@%0d", c), if_c.CPCE, 0);
            end
            if (c >= 4 && c < 20 && (c % 4) == 1) begin
                chk($sformatf("C_sel@%0d", c), if_c.BUSSEL, ((c / 4) % 2 == 1) ? 1 : 3);
            end
            if (c == 7 || c == 19) begin
                exp_ce_c = (c == 7) ? 4'b0010 : 4'b1000;
                chk($sformatf("C_cpce@%0d", c), if_c.CPCE, exp_ce_c);
            end
            if (c == 9) chk("C_busrd_active", if_c.BUSRD, 1);
            if (c >= 20) begin
                chk($sformatf("C_idle_busact@%0d", c), if_c.BUSACT, 0);
                chk($sformatf("C_idle_cpce@%0d", c), if_c.CPCE, 0);
                chk($sformatf("C_idle_busrd@%0d", c), if_c.BUSRD, 0);
                chk($sformatf("C_idle_buswr@%0d", c), if_c.BUSWR, 0);
                chk($sformatf("C_idle_sel@%0d", c), if_c.BUSSEL, 3);
            end

            chk($sformatf("D_cpce@%0d", c), if_d.CPCE, (c % 3) == 2);

            @(negedge clk);
        end

        // Continue to cycle 30: slot 7 (owner 1) at phase 2.
        repeat (2) @(negedge clk);
        chk("A_pre_sel", if_a.BUSSEL, 1);
        chk("A_pre_hold0", if_a.CPID[7:0], 8'h3C);
        chk("B_pre_hold2", if_b.CPID[23:16], 8'h11);

        // Reset in mid-slot: the would-be CPCE[1] cycle must stay quiet.
        rst = 1'b1;
        @(negedge clk);
        chk("R_cpce", if_a.CPCE, 0);
        chk("R_sel", if_a.BUSSEL, 0);
        chk("R_cpid1", if_a.CPID[15:8], 8'hFF);
        chk("R_b_cpid1", if_b.CPID[15:8], 8'hFF);
        chk("R_b_cpid2", if_b.CPID[23:16], 8'hFF);
        rst = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("R_cpce@%0d", c), if_a.CPCE, (c == 3) ? 2'b01 : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
